sprite_frame_scheduler: RTL and testbench

Frame-rate controller that owns the single pixel-write port of the 160x120 VGA adapter and shares it among up to `NUM_SPRITES` 4x4 sprite movers. On every frame tick it services the sprites in index order. For each sprite it erases the 4x4 block at the previously drawn position, pulses that sprite's move request, samples the new position, and draws the block in the sprite's colour. It sits between the per-sprite position updaters and `vga_adapter`, and replaces ad-hoc per-sprite erase/move/draw FSMs.

---
 rtl/sprite_frame_scheduler.sv | 132 +++++++++++++
 tb/tb_sprite_frame_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler: per-frame erase/move/draw sequencer sharing one VGA pixel port among 4x4 sprites.
// Optional SPRITE_CLIP_EN suppresses plots that fall outside the 160x120 screen.
module sprite_frame_scheduler #(
  parameter int NUM_SPRITES = 2,
  parameter int TICK_DIV    = 833333
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [8*NUM_SPRITES-1:0] sprite_x,
  input  logic [7*NUM_SPRITES-1:0] sprite_y,
  input  logic [3*NUM_SPRITES-1:0] sprite_colour,
  output logic [NUM_SPRITES-1:0]   move_req,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     frame_overrun
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, ERASE, MOVE, SETTLE, DRAW, NEXT} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0] r_i, w_i_nxt, r_p, w_p_nxt;
  logic [2:0] w_k;
  logic [7:0] r_valid;
  logic [7:0] r_old_x [8];
  logic [6:0] r_old_y [8];
  logic [2:0] r_col, w_c;
  logic [7:0] w_bx, w_x;
  logic [6:0] w_by, w_y;
  logic w_tick, w_start, w_pix, w_plot;
  logic [NUM_SPRITES-1:0] r_move;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_col;
  logic r_plot, r_busy, r_ovr;

  assign w_tick  = r_cnt == CW'(TICK_DIV - 1);
  assign w_start = w_tick && enable && !r_busy;
  assign w_k     = (w_i_nxt < 4'(NUM_SPRITES)) ? w_i_nxt[2:0] : 3'd0;
  assign w_p_nxt = (r_state == ERASE || r_state == DRAW) ? r_p + 4'd1 : 4'd0;
  assign w_pix   = w_next == ERASE || w_next == DRAW;
  // DRAW entered from SETTLE uses the live inputs, which are latched on that same edge
  assign w_bx    = (r_state == SETTLE) ? sprite_x[8*w_k +: 8] : r_old_x[w_k];
  assign w_by    = (r_state == SETTLE) ? sprite_y[7*w_k +: 7] : r_old_y[w_k];
  assign w_c     = (w_next != DRAW) ? 3'd0 : (r_state == SETTLE) ? sprite_colour[3*w_k +: 3] : r_col;
  assign w_x     = w_bx + {6'd0, w_p_nxt[1:0]};
  assign w_y     = w_by + {5'd0, w_p_nxt[3:2]};
`ifdef SPRITE_CLIP_EN
  assign w_plot  = w_pix && w_x <= 8'd159 && w_y <= 7'd119;
`else
  assign w_plot  = w_pix;
`endif

  assign move_req      = r_move;
  assign vga_x         = r_vga_x;
  assign vga_y         = r_vga_y;
  assign vga_colour    = r_vga_col;
  assign plot          = r_plot;
  assign busy          = r_busy;
  assign frame_overrun = r_ovr;

  // next state and sprite index; a new sprite erases only if it was drawn before
  always_comb begin
    w_next  = r_state;
    w_i_nxt = r_i;
    case (r_state)
      IDLE:   if (w_start) begin
                w_i_nxt = 4'd0;
                w_next  = r_valid[0] ? ERASE : MOVE;
              end
      ERASE:  w_next = (r_p == 4'd15) ? MOVE : ERASE;
      MOVE:   w_next = SETTLE;
      SETTLE: w_next = DRAW;
      DRAW:   w_next = (r_p == 4'd15) ? NEXT : DRAW;
      NEXT:   begin
                w_i_nxt = r_i + 4'd1;
                w_next  = (w_i_nxt == 4'(NUM_SPRITES)) ? IDLE : r_valid[w_i_nxt[2:0]] ? ERASE : MOVE;
              end
      default: w_next = IDLE;
    endcase
  end

  // free-running frame tick divider
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else r_cnt <= w_tick ? '0 : r_cnt + CW'(1);

  // sequencer state, pixel counter, valid flags and sticky overrun
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE;
      r_i     <= 4'd0;
      r_p     <= 4'd0;
      r_valid <= 8'd0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_i     <= w_i_nxt;
      r_p     <= w_p_nxt;
      r_ovr   <= r_ovr | (w_tick && r_busy);
      if (r_state == SETTLE) r_valid[w_k] <= 1'b1;
    end

  // position and colour snapshot taken at the end of SETTLE
  always_ff @(posedge clk)
    if (r_state == SETTLE) begin
      r_old_x[w_k] <= sprite_x[8*w_k +: 8];
      r_old_y[w_k] <= sprite_y[7*w_k +: 7];
      r_col        <= sprite_colour[3*w_k +: 3];
    end

  // registered outputs computed from the state being entered
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_move    <= '0;
      r_vga_x   <= 8'd0;
      r_vga_y   <= 7'd0;
      r_vga_col <= 3'd0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_move    <= (w_next == MOVE) ? NUM_SPRITES'(1) << w_k : '0;
      r_vga_x   <= w_x;
      r_vga_y   <= w_y;
      r_vga_col <= w_c;
      r_plot    <= w_plot;
      r_busy    <= w_next != IDLE;
    end
endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb_sprite_frame_scheduler: scoreboard bench with a +1/+1 sprite mover model.
module tb_sprite_frame_scheduler;
  localparam int NS = 2;
  localparam int TD = 50;
  typedef struct {int cyc; int x; int y; int col;} pix_t;
  typedef struct {int cyc; int mask;} mv_t;
  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0;
  logic [8*NS-1:0] sprite_x;
  logic [7*NS-1:0] sprite_y;
  logic [3*NS-1:0] sprite_colour;
  logic [NS-1:0] move_req;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic plot, busy, frame_overrun;
  int checks = 0, errors = 0;
  pix_t pq[$];
  mv_t mq[$];
  int c, bstart, bend;
  bit ovf;
  bit vld[NS];
  int ox[NS], oy[NS], px[NS], py[NS], col[NS];

  always #5 clk = ~clk;

  sprite_frame_scheduler #(.NUM_SPRITES(NS), .TICK_DIV(TD)) u_dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_colour(sprite_colour),
    .move_req(move_req), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .frame_overrun(frame_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, c, got, exp);
    end
  endtask

  task automatic drive_pos();
    for (int k = 0; k < NS; k++) begin
      sprite_x[8*k +: 8]      = 8'(px[k]);
      sprite_y[7*k +: 7]      = 7'(py[k]);
      sprite_colour[3*k +: 3] = 3'(col[k]);
    end
  endtask

  task automatic push_pix(input int cy, input int x, input int y, input int cl);
    pix_t e;
    e.cyc = cy;
    e.x   = x % 256;
    e.y   = y % 128;
    e.col = cl;
`ifdef SPRITE_CLIP_EN
    if (e.x > 159 || e.y > 119) return;
`endif
    pq.push_back(e);
  endtask

  task automatic build_frame(input int t);
    int s;
    mv_t m;
    s = t + 1;
    bstart = s;
    for (int k = 0; k < NS; k++) begin
      if (vld[k]) begin
        for (int p = 0; p < 16; p++) push_pix(s + p, ox[k] + p % 4, oy[k] + p / 4, 0);
        s += 16;
      end
      m.cyc = s;
      m.mask = 1 << k;
      mq.push_back(m);
      ox[k] = (px[k] + 1) % 256;
      oy[k] = (py[k] + 1) % 128;
      for (int p = 0; p < 16; p++) push_pix(s + 2 + p, ox[k] + p % 4, oy[k] + p / 4, col[k]);
      vld[k] = 1'b1;
      s += 19;
    end
    bend = s - 1;
  endtask

  task automatic model_reset();
    c = 0;
    bstart = 1;
    bend = 0;
    ovf = 1'b0;
    for (int k = 0; k < NS; k++) vld[k] = 1'b0;
    pq.delete();
    mq.delete();
  endtask

  task automatic step();
    pix_t e;
    mv_t m;
    bit b;
    @(negedge clk);
    c++;
    b = c >= bstart && c <= bend;
    chk("busy", busy, b);
    chk("overrun", frame_overrun, ovf);
    if (pq.size() > 0 && pq[0].cyc == c) begin
      e = pq.pop_front();
      chk("plot_on", plot, 1);
      chk("vga_x", vga_x, e.x);
      chk("vga_y", vga_y, e.y);
      chk("vga_colour", vga_colour, e.col);
    end else chk("plot_off", plot, 0);
    if (mq.size() > 0 && mq[0].cyc == c) begin
      m = mq.pop_front();
      chk("move_req", move_req, m.mask);
    end else chk("move_idle", move_req, 0);
    for (int k = 0; k < NS; k++)
      if (move_req[k]) begin
        px[k] = (px[k] + 1) % 256;
        py[k] = (py[k] + 1) % 128;
      end
    drive_pos();
    if (c % TD == TD - 1) begin
      if (b) ovf = 1'b1;
      else if (enable) build_frame(c);
    end
  endtask

  initial begin
    px[0] = 49;  py[0] = 59;  col[0] = 7;
    px[1] = 157; py[1] = 117; col[1] = 5;
    drive_pos();
    enable = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_move_req", move_req, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_vga_colour", vga_colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", frame_overrun, 0);
    resetn = 1'b1;
    // ticks at 49 (no erase), 99 (erase), 149 (overrun), 199; reset in 5th DRAW cycle (222)
    while (c < 222) step();
    #2 resetn = 1'b0;
    #1;
    chk("async_plot", plot, 0);
    chk("async_busy", busy, 0);
    chk("async_overrun", frame_overrun, 0);
    repeat (2) @(negedge clk);
    model_reset();
    resetn = 1'b1;
    // tick 49 dropped with enable low; enable falls mid-frame after tick 99
    while (c < 230) begin
      step();
      if (c == 30 || c == 110) enable = 1'b0;
      if (c == 60 || c == 140) enable = 1'b1;
    end
    chk("pix_queue_empty", pq.size(), 0);
    chk("move_queue_empty", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
